// File: rtl/bcd_display_mux.sv
// -----------------------------------------------------------------------------
// bcd_display_mux
//
// Multiplexed 7-segment display driver placed downstream of a binary-to-BCD
// converter. A packed BCD word is captured on each `load` edge, together with
// a leading-zero blanking mask and an invalid-nibble flag. The captured digits
// are then scanned onto a shared segment bus. Each digit is driven for
// `scandiv` cycles, and a one-cycle dark gap separates neighbouring digits to
// suppress ghosting.
//
// Parameters
//   bcdwidth : packed BCD input width (multiple of 4)
//   bcddigit : number of digits / anode lines (bcdwidth/4)
//   scandiv  : clock cycles each digit is driven per slot (>= 1)
//
// Ports
//   clock  in   system clock, rising-edge active
//   reset  in   synchronous active-high reset
//   load   in   capture strobe (level, sampled every edge)
//   bcd    in   packed BCD word, digit 0 in bcd[3:0]
//   lzb    in   leading-zero blanking enable, sampled with load
//   seg    out  segment drive {g,f,e,d,c,b,a}, active high, registered
//   an     out  digit enables, one-hot or all zero, registered
//   err    out  last captured word held a nibble > 9, registered
// -----------------------------------------------------------------------------
module bcd_display_mux #(
  parameter int bcdwidth = 16,
  parameter int bcddigit = bcdwidth / 4,
  parameter int scandiv  = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [bcdwidth-1:0] bcd,
  input  logic                lzb,
  output logic [6:0]          seg,
  output logic [bcddigit-1:0] an,
  output logic                err
);

  localparam int pc_w  = (scandiv  > 1) ? $clog2(scandiv)  : 1;
  localparam int idx_w = (bcddigit > 1) ? $clog2(bcddigit) : 1;

  localparam logic [pc_w-1:0]  pc_last  = pc_w'(scandiv - 1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(bcddigit - 1);

  // After reset the buffer holds zero, so every digit above digit 0 is dark.
  localparam logic [bcddigit-1:0] mask_rst = {bcddigit{1'b1}} << 1;

  typedef enum logic {
    DRIVE = 1'b0,
    GAP   = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Segment decoder: 0-9 map to the usual glyphs, anything else shows a dash.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
    return glyph;
  endfunction

  // ---------------------------------------------------------------------------
  // Capture path: display buffer, blank mask and invalid-nibble flag.
  // ---------------------------------------------------------------------------
  logic [bcdwidth-1:0] buffer;
  logic [bcddigit-1:0] mask;
  logic                err_flag;

  logic [bcddigit-1:0] mask_new;
  logic                bad_new;
  logic                zero_above;

  // Walk from the most significant digit downwards. A digit is blanked only
  // while every nibble from it up to the top is zero. Invalid nibbles are
  // nonzero, so they end the blank run like any other digit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so
    // this block can never infer a latch.
    mask_new   = '0;
    bad_new    = 1'b0;
    zero_above = 1'b1;
    for (int j = bcddigit - 1; j >= 1; j--) begin
      zero_above  = zero_above & (bcd[j*4 +: 4] == 4'd0);
      mask_new[j] = lzb & zero_above;
    end
    for (int j = 0; j < bcddigit; j++) begin
      if (bcd[j*4 +: 4] > 4'd9) begin
        bad_new = 1'b1;
      end
    end
  end

  // The display buffer is a handful of flops rather than a memory. It is
  // reset so the panel shows a clean "0" as soon as reset is released.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that were present before this edge.
    if (reset) begin
      buffer   <= '0;
      mask     <= mask_rst;
      err_flag <= 1'b0;
    end else if (load) begin
      buffer   <= bcd;
      mask     <= mask_new;
      err_flag <= bad_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: state register.
  // ---------------------------------------------------------------------------
  state_t            state, state_next;
  logic [pc_w-1:0]   pc, pc_next;
  logic [idx_w-1:0]  idx, idx_next;

  // The scan position depends only on time since reset. `load` has no
  // effect on it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DRIVE;
      pc    <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      idx   <= idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next-state and next-output logic.
  // ---------------------------------------------------------------------------
  logic [6:0]          seg_next;
  logic [bcddigit-1:0] an_next;
  logic [3:0]          digit;
  logic                blank;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    idx_next   = idx;
    seg_next   = 7'h00;
    an_next    = '0;
    digit      = 4'd0;
    blank      = 1'b0;

    // Select the current digit with a compare loop. This avoids a variable
    // part-select when bcddigit is not a power of two.
    for (int j = 0; j < bcddigit; j++) begin
      if (idx == idx_w'(j)) begin
        digit = buffer[j*4 +: 4];
        blank = mask[j];
      end
    end

    unique case (state)
      DRIVE: begin
        for (int j = 0; j < bcddigit; j++) begin
          an_next[j] = (idx == idx_w'(j));
        end
        seg_next = blank ? 7'h00 : decode(digit);
        if (pc == pc_last) begin
          pc_next    = '0;
          state_next = GAP;
        end else begin
          pc_next = pc + pc_w'(1);
        end
      end
      GAP: begin
        // The panel stays dark for one cycle, then the scan moves on.
        idx_next   = (idx == idx_last) ? '0 : idx + idx_w'(1);
        state_next = DRIVE;
      end
      default: begin
        state_next = DRIVE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers. `err` is registered from err_flag, which puts it one
  // edge behind the capture. A load at edge N therefore shows up on `seg`
  // and `err` together at edge N+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      seg <= 7'h00;
      an  <= '0;
      err <= 1'b0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      err <= err_flag;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_mux
//
// Scoreboard bench for bcd_display_mux (16-bit word, 4 digits, scandiv = 4).
// The stimulus process works out the expected {seg, an, err} for each clock
// edge and queues it. The model uses frame/slot arithmetic on a cycle count
// and plain integer maths on the captured word. A separate monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bcd_display_mux;

  localparam int W     = 16;
  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int SLOT  = SD + 1;
  localparam int FRAME = ND * SLOT;

  logic          clock = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  bcd;
  logic          lzb;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          err;

  bcd_display_mux #(
    .bcdwidth(W),
    .bcddigit(ND),
    .scandiv (SD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load (load),
    .bcd  (bcd),
    .lzb  (lzb),
    .seg  (seg),
    .an   (an),
    .err  (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int seg;
    int an;
    int err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: the word and lzb the display currently shows, and
  // the number of non-reset edges since the last reset.
  int m_word = 0;
  int m_lz   = 1;
  int m_k    = 0;

  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic int nib(input int w, input int d);
    return (w >> (4 * d)) & 15;
  endfunction

  function automatic int ref_seg(input int w, input int lz, input int d);
    int n;
    // A digit is blank when the value formed by it and all higher digits is 0.
    if (lz != 0 && d > 0 && (w >> (4 * d)) == 0) return 0;
    n = nib(w, d);
    return (n <= 9) ? seg_tab[n] : 'h40;
  endfunction

  function automatic int ref_err(input int w);
    for (int d = 0; d < ND; d++) begin
      if (nib(w, d) > 9) return 1;
    end
    return 0;
  endfunction

  function automatic int rand_word();
    int w    = 0;
    int lead = $urandom_range(0, ND);
    int n;
    for (int d = 0; d < ND; d++) begin
      n = ($urandom % 8 == 0) ? int'($urandom % 16) : int'($urandom % 10);
      if (d > 0 && d >= ND - lead) n = 0;
      w = w | (n << (4 * d));
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input bit r, input bit l, input int v, input bit z);
    exp_t e;
    int   p;
    int   d;
    reset = r;
    load  = l;
    bcd   = W'(v);
    lzb   = z;
    if (r) begin
      e      = '{0, 0, 0};
      m_word = 0;
      m_lz   = 1;
      m_k    = 0;
    end else begin
      p = m_k % FRAME;
      if (p % SLOT == SD) begin
        e = '{0, 0, ref_err(m_word)};
      end else begin
        d = p / SLOT;
        e = '{ref_seg(m_word, m_lz, d), 1 << d, ref_err(m_word)};
      end
      m_k++;
      if (l) begin
        m_word = v & 'hFFFF;
        m_lz   = int'(z);
      end
    end
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, rand_word(), 1'($urandom % 2));
    end
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg", 8'(seg), 8'(e.seg));
        check("an",  8'(an),  8'(e.an));
        check("err", 8'(err), 8'(e.err));
      end
    end
  end

  initial begin
    // Reset held with a competing load: the load must be lost.
    repeat (3) step(1'b1, 1'b1, 'h9999, 1'b1);
    idle(22);

    // Full scan without blanking.
    step(1'b0, 1'b1, 'h1234, 1'b0);
    idle(40);

    // Leading-zero blanking cases.
    step(1'b0, 1'b1, 'h0050, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 'h0050, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 'h0000, 1'b1);
    idle(20);

    // Invalid nibble, then a valid load clears err.
    step(1'b0, 1'b1, 'h1A23, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 'h0001, 1'b0);
    idle(5);

    // Load on the 2nd DRIVE cycle of digit 0.
    while (m_k % FRAME != 0) idle(1);
    idle(1);
    step(1'b0, 1'b1, 'h0007, 1'b0);
    idle(10);

    // Reset during digit 2's slot.
    while (m_k % FRAME != 11) idle(1);
    step(1'b1, 1'b0, 'h4321, 1'b0);
    step(1'b1, 1'b1, 'h4321, 1'b0);
    idle(10);

    // Load held for several cycles: the last value wins.
    step(1'b0, 1'b1, 'h1111, 1'b0);
    step(1'b0, 1'b1, 'h2222, 1'b0);
    step(1'b0, 1'b1, 'h0308, 1'b1);
    idle(20);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 200) == 0, ($urandom % 6) == 0, rand_word(), 1'($urandom % 2));
    end

    check("drain", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
